// File: rtl/memory_buffer_register.sv
// ============================================================================
// Module   : memory_buffer_register
// Brief    : G memory buffer register with write-bus edits, sense loads,
//            odd-parity generation and a two-state parity checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_buffer_register (
    input  logic        SIM_CLK,
    input  logic        SIM_RST,
    input  logic [15:0] WL_n,
    input  logic        WGG_n,
    input  logic [15:0] SA,
    input  logic        SAP,
    input  logic        RSA,
    input  logic        CGG,
    input  logic        CYR_n,
    input  logic        SR_n,
    input  logic        CYL_n,
    input  logic        EDOP_n,
    input  logic        TPARG_n,
    input  logic        MONPAR,
    output logic [15:0] G,
    output logic        GP,
    output logic        PERR,
    output logic        PALARM
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CHECK = 1'b1
    } state_t;

    state_t      r_state;
    logic [15:0] r_g;
    logic        r_gp;
    logic        r_perr;
    logic        r_palarm;

    logic [15:0] w_wbus;
    logic        w_wgg;
    logic [3:0]  w_sel;
    logic        w_edit_ok;
    logic [15:0] w_write_word;
    logic        w_gen_par;
    logic        w_stored_bad;
    logic        w_check_req;

    assign w_wbus    = ~WL_n;
    assign w_wgg     = ~WGG_n;
    // Edit select order: [3]=CYR, [2]=SR, [1]=CYL, [0]=EDOP
    assign w_sel     = ~{CYR_n, SR_n, CYL_n, EDOP_n};
    assign w_edit_ok = w_wgg & $onehot(w_sel);

    // Bit 14 is the overflow bit; bit 15 carries the sign copy for the shifts.
    always_comb begin
        w_write_word = w_wbus;
        if (w_edit_ok) begin
            if (w_sel[3]) begin
                w_write_word = {w_wbus[0], w_wbus[0], w_wbus[14:1]};
            end else if (w_sel[2]) begin
                w_write_word = {w_wbus[14], w_wbus[14], w_wbus[14:1]};
            end else if (w_sel[1]) begin
                w_write_word = {w_wbus[13], w_wbus[13:0], w_wbus[14]};
            end else begin
                w_write_word = {9'd0, w_wbus[13:7]};
            end
        end
    end

    assign w_gen_par    = ~(^{w_write_word[15], w_write_word[13:0]}) ^ MONPAR;
    assign w_stored_bad = ~(^{r_g[15], r_g[13:0], r_gp});
    assign w_check_req  = RSA & ~TPARG_n;

    // Simultaneous sense and write loads merge as a wired-OR bus.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_g  <= 16'h0000;
            r_gp <= 1'b0;
        end else if (RSA && w_wgg) begin
            r_g  <= SA | w_write_word;
            r_gp <= SAP | w_gen_par;
        end else if (RSA) begin
            r_g  <= SA;
            r_gp <= SAP;
        end else if (w_wgg) begin
            r_g  <= w_write_word;
            r_gp <= w_gen_par;
        end else if (CGG) begin
            r_g  <= 16'h0000;
            r_gp <= 1'b0;
        end
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_state  <= S_IDLE;
            r_perr   <= 1'b0;
            r_palarm <= 1'b0;
        end else begin
            r_perr <= 1'b0;
            if (r_state == S_CHECK && w_stored_bad) begin
                r_perr   <= 1'b1;
                r_palarm <= 1'b1;
            end
            r_state <= w_check_req ? S_CHECK : S_IDLE;
        end
    end

    assign G      = r_g;
    assign GP     = r_gp;
    assign PERR   = r_perr;
    assign PALARM = r_palarm;

endmodule

`default_nettype wire

// File: tb/tb_memory_buffer_register.sv
// ============================================================================
// Module   : tb_memory_buffer_register
// Brief    : Directed self-checking bench for memory_buffer_register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_buffer_register;

    logic        SIM_CLK;
    logic        SIM_RST;
    logic [15:0] WL_n;
    logic        WGG_n;
    logic [15:0] SA;
    logic        SAP;
    logic        RSA;
    logic        CGG;
    logic        CYR_n;
    logic        SR_n;
    logic        CYL_n;
    logic        EDOP_n;
    logic        TPARG_n;
    logic        MONPAR;
    logic [15:0] G;
    logic        GP;
    logic        PERR;
    logic        PALARM;

    int tests_run    = 0;
    int tests_failed = 0;

    memory_buffer_register dut (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .WL_n    (WL_n),
        .WGG_n   (WGG_n),
        .SA      (SA),
        .SAP     (SAP),
        .RSA     (RSA),
        .CGG     (CGG),
        .CYR_n   (CYR_n),
        .SR_n    (SR_n),
        .CYL_n   (CYL_n),
        .EDOP_n  (EDOP_n),
        .TPARG_n (TPARG_n),
        .MONPAR  (MONPAR),
        .G       (G),
        .GP      (GP),
        .PERR    (PERR),
        .PALARM  (PALARM)
    );

    initial SIM_CLK = 1'b0;
    always #5 SIM_CLK = ~SIM_CLK;

    task automatic tick();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic idle_inputs();
        WL_n    = 16'hFFFF;
        WGG_n   = 1'b1;
        SA      = 16'h0000;
        SAP     = 1'b0;
        RSA     = 1'b0;
        CGG     = 1'b0;
        CYR_n   = 1'b1;
        SR_n    = 1'b1;
        CYL_n   = 1'b1;
        EDOP_n  = 1'b1;
        TPARG_n = 1'b1;
        MONPAR  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        SIM_RST = 1'b1;
        tick();
        tick();
        SIM_RST = 1'b0;
    endtask

    task automatic test_reset();
        SIM_RST = 1'b1;
        idle_inputs();
        WL_n  = ~16'h1234;
        WGG_n = 1'b0;
        RSA   = 1'b1;
        SA    = 16'hFFFF;
        tick();
        tick();
        tests_run++;
        if (G !== 16'h0000) begin tests_failed++; $display("FAIL reset_g got=%h exp=%h", G, 16'h0000); end
        tests_run++;
        if (GP !== 1'b0) begin tests_failed++; $display("FAIL reset_gp got=%b exp=0", GP); end
        tests_run++;
        if (PERR !== 1'b0) begin tests_failed++; $display("FAIL reset_perr got=%b exp=0", PERR); end
        tests_run++;
        if (PALARM !== 1'b0) begin tests_failed++; $display("FAIL reset_palarm got=%b exp=0", PALARM); end
        SIM_RST = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_plain_write();
        logic [15:0] w_vec [4] = '{16'h0005, 16'h4000, 16'h8001, 16'h0007};
        logic        p_vec [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            WL_n  = ~w_vec[i];
            WGG_n = 1'b0;
            tick();
            idle_inputs();
            tests_run++;
            if (G !== w_vec[i]) begin tests_failed++; $display("FAIL plain_g[%0d] got=%h exp=%h", i, G, w_vec[i]); end
            tests_run++;
            if (GP !== p_vec[i]) begin tests_failed++; $display("FAIL plain_gp[%0d] got=%b exp=%b", i, GP, p_vec[i]); end
        end
        // Edit selects without WGG and no strobes must hold the last word.
        CYR_n = 1'b0;
        tick();
        tick();
        idle_inputs();
        tests_run++;
        if (G !== 16'h0007 || GP !== 1'b0) begin
            tests_failed++; $display("FAIL hold got=%h/%b exp=0007/0", G, GP);
        end
        CGG = 1'b1;
        tick();
        idle_inputs();
        tests_run++;
        if (G !== 16'h0000 || GP !== 1'b0) begin
            tests_failed++; $display("FAIL cgg_clear got=%h/%b exp=0000/0", G, GP);
        end
    endtask

    task automatic test_edits();
        // mask: [3]=CYR [2]=SR [1]=CYL [0]=EDOP (active-high in the table)
        logic [15:0] w_vec [6] = '{16'h0001, 16'h0001, 16'h4000, 16'h3F80, 16'h0001, 16'h2003};
        logic [3:0]  m_vec [6] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b0010};
        logic [15:0] g_vec [6] = '{16'hC000, 16'h0000, 16'h0001, 16'h007F, 16'h0001, 16'hC006};
        logic        p_vec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            WL_n   = ~w_vec[i];
            WGG_n  = 1'b0;
            CYR_n  = ~m_vec[i][3];
            SR_n   = ~m_vec[i][2];
            CYL_n  = ~m_vec[i][1];
            EDOP_n = ~m_vec[i][0];
            tick();
            idle_inputs();
            tests_run++;
            if (G !== g_vec[i]) begin tests_failed++; $display("FAIL edit_g[%0d] got=%h exp=%h", i, G, g_vec[i]); end
            tests_run++;
            if (GP !== p_vec[i]) begin tests_failed++; $display("FAIL edit_gp[%0d] got=%b exp=%b", i, GP, p_vec[i]); end
        end
    endtask

    task automatic test_sense_parity();
        do_reset();
        SA = 16'h0003; SAP = 1'b0; RSA = 1'b1; TPARG_n = 1'b0;
        tick();
        idle_inputs();
        tests_run++;
        if (G !== 16'h0003 || GP !== 1'b0) begin tests_failed++; $display("FAIL sense_load got=%h/%b exp=0003/0", G, GP); end
        tests_run++;
        if (PERR !== 1'b0) begin tests_failed++; $display("FAIL sense_perr_early got=%b exp=0", PERR); end
        tick();
        tests_run++;
        if (PERR !== 1'b1 || PALARM !== 1'b1) begin tests_failed++; $display("FAIL sense_perr got=%b/%b exp=1/1", PERR, PALARM); end
        tick();
        tests_run++;
        if (PERR !== 1'b0 || PALARM !== 1'b1) begin tests_failed++; $display("FAIL sense_pulse_end got=%b/%b exp=0/1", PERR, PALARM); end
        SA = 16'h0003; SAP = 1'b1; RSA = 1'b1; TPARG_n = 1'b0;
        tick();
        idle_inputs();
        tick();
        tests_run++;
        if (PERR !== 1'b0 || PALARM !== 1'b1) begin tests_failed++; $display("FAIL sense_good got=%b/%b exp=0/1", PERR, PALARM); end
        do_reset();
        tests_run++;
        if (PALARM !== 1'b0) begin tests_failed++; $display("FAIL palarm_clear got=%b exp=0", PALARM); end
        // Bad word with the test disabled must not alarm.
        SA = 16'h0003; SAP = 1'b0; RSA = 1'b1; TPARG_n = 1'b1;
        tick();
        idle_inputs();
        tick();
        tests_run++;
        if (PERR !== 1'b0 || PALARM !== 1'b0) begin tests_failed++; $display("FAIL tparg_off got=%b/%b exp=0/0", PERR, PALARM); end
    endtask

    task automatic test_wired_or();
        do_reset();
        SA = 16'h00F0; SAP = 1'b0; RSA = 1'b1;
        WL_n = ~16'h000F; WGG_n = 1'b0; CGG = 1'b1;
        tick();
        idle_inputs();
        tests_run++;
        if (G !== 16'h00FF || GP !== 1'b1) begin tests_failed++; $display("FAIL wired_or got=%h/%b exp=00FF/1", G, GP); end
    endtask

    task automatic test_monpar();
        do_reset();
        WL_n = ~16'h0005; WGG_n = 1'b0; MONPAR = 1'b1;
        tick();
        idle_inputs();
        tests_run++;
        if (G !== 16'h0005 || GP !== 1'b0) begin tests_failed++; $display("FAIL monpar_write got=%h/%b exp=0005/0", G, GP); end
        SA = 16'h0005; SAP = 1'b0; RSA = 1'b1; TPARG_n = 1'b0;
        tick();
        idle_inputs();
        tick();
        tests_run++;
        if (PERR !== 1'b1) begin tests_failed++; $display("FAIL monpar_perr got=%b exp=1", PERR); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] sa_vec [4] = '{16'h0003, 16'h0003, 16'h0001, 16'h0000};
        logic        sp_vec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        // PERR after each edge reports the word loaded one edge earlier.
        logic        pe_vec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                SA = sa_vec[i]; SAP = sp_vec[i]; RSA = 1'b1; TPARG_n = 1'b0;
            end else begin
                idle_inputs();
            end
            tick();
            tests_run++;
            if (PERR !== pe_vec[i]) begin tests_failed++; $display("FAIL b2b_perr[%0d] got=%b exp=%b", i, PERR, pe_vec[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_check();
        do_reset();
        SA = 16'h0003; SAP = 1'b0; RSA = 1'b1; TPARG_n = 1'b0;
        tick();
        idle_inputs();
        SIM_RST = 1'b1;
        tick();
        tests_run++;
        if (PERR !== 1'b0 || PALARM !== 1'b0 || G !== 16'h0000) begin
            tests_failed++; $display("FAIL rst_in_check got=%b/%b/%h exp=0/0/0000", PERR, PALARM, G);
        end
        SIM_RST = 1'b0;
        tick();
        tests_run++;
        if (PERR !== 1'b0 || PALARM !== 1'b0) begin tests_failed++; $display("FAIL rst_after_check got=%b/%b exp=0/0", PERR, PALARM); end
    endtask

    initial begin
        idle_inputs();
        SIM_RST = 1'b1;
        test_reset();
        test_plain_write();
        test_edits();
        test_sense_parity();
        test_wired_or();
        test_monpar();
        test_back_to_back();
        test_reset_in_check();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_buffer_register.md
MEMORY_BUFFER_REGISTER -- requirements
Module: memory_buffer_register

Interface
REQ-001 SHALL have port SIM_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port SIM_RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port WL_n, input, 16 bits: write bus, active-low; bit 0 = WL01_n … bit 15 = WL16_n.
REQ-004 SHALL have port WGG_n, input, 1 bit: active-low strobe that loads G from the write bus.
REQ-005 SHALL have port SA, input, 16 bits: sense-amplifier data word, active-high, same bit mapping as G.
REQ-006 SHALL have port SAP, input, 1 bit: sense-amplifier parity bit.
REQ-007 SHALL have port RSA, input, 1 bit: active-high strobe that loads G and GP from SA/SAP.
REQ-008 SHALL have port CGG, input, 1 bit: active-high clear of G and GP.
REQ-009 SHALL have ports CYR_n, SR_n, CYL_n, EDOP_n, input, 1 bit each: active-low edit selects, as produced by the parity/S-register stage.
REQ-010 SHALL have port TPARG_n, input, 1 bit: active-low parity-test enable, sampled with RSA.
REQ-011 SHALL have port MONPAR, input, 1 bit: when high, the generated write parity is inverted (alarm self-test).
REQ-012 SHALL have port G, output, 16 bits: register contents G01..G16 (bit 0 = G01), feeding the parity/S-register stage.
REQ-013 SHALL have port GP, output, 1 bit: parity bit held with G.
REQ-014 SHALL have port PERR, output, 1 bit: one-cycle parity-fail pulse.
REQ-015 SHALL have port PALARM, output, 1 bit: sticky parity alarm.

Function
REQ-016 Let W = ~WL_n; data bits are W[13:0] plus W[15]; W[14] is the overflow bit and SHALL NOT take part in parity.
REQ-017 SHALL decode the edit select as active only when WGG_n is low and exactly one of CYR_n, SR_n, CYL_n, EDOP_n is low; none low SHALL mean a plain write.
REQ-018 A plain write SHALL set G <= W.
REQ-019 CYR SHALL set G[14:0] <= {W[0], W[14:1]} and G[15] <= W[0].
REQ-020 SR SHALL set G[14:0] <= {W[14], W[14:1]} and G[15] <= W[14].
REQ-021 CYL SHALL set G[14:0] <= {W[13:0], W[14]} and G[15] <= W[13].
REQ-022 EDOP SHALL set G[6:0] <= W[13:7] and clear all other G bits.
REQ-023 When two or more edit selects are low with WGG_n low, the write SHALL be treated as plain and no edit shall be applied.
REQ-024 On every WGG write, GP SHALL be set so that the total count of ones over G[13:0], G[15] and GP is odd (odd parity), then XORed with MONPAR.
REQ-025 RSA SHALL set G <= SA and GP <= SAP.
REQ-026 If RSA and WGG_n are asserted in the same cycle, G SHALL be loaded with the bitwise OR of both sources (wired-OR bus), and GP SHALL be the OR of SAP and the generated parity.
REQ-027 CGG SHALL clear G and GP only when neither RSA nor WGG_n is asserted; a load SHALL win over a same-cycle clear.
REQ-028 With no strobe asserted, G and GP SHALL hold.
REQ-029 Parity check SHALL be a two-state FSM, IDLE and CHECK.
REQ-030 The FSM SHALL go IDLE->CHECK on a cycle where RSA is high and TPARG_n is low, and SHALL return CHECK->IDLE unconditionally after one cycle.
REQ-031 In CHECK, the block SHALL evaluate the parity of the loaded G[13:0], G[15] and GP; an even count SHALL assert PERR for exactly that cycle and set PALARM.
REQ-032 Back-to-back RSA with TPARG_n low SHALL re-enter CHECK every cycle; each check SHALL use the word loaded in the preceding cycle.
REQ-033 PALARM SHALL remain set until SIM_RST.
REQ-034 Latency: G and GP SHALL be visible one clock after the strobe; PERR SHALL appear one clock after the RSA load.

Reset
REQ-035 When SIM_RST is high at a clock edge, it SHALL override all strobes.
REQ-036 Reset values: G = 16'h0000, GP = 0, PERR = 0, PALARM = 0, FSM = IDLE.
REQ-037 SIM_RST asserted while the FSM is in CHECK SHALL suppress the pending PERR pulse.

Verification
REQ-038 Plain write: WL_n = ~16'h0005, WGG_n = 0 -> G = 16'h0005 and GP = 1 (two ones, so the parity bit makes the count odd).
REQ-039 Edits on W = 16'h0001: CYR -> G = 16'hC000; SR -> G = 16'h0000. Edits on W = 16'h4000: CYL -> G = 16'h0001. Edit on W = 16'h3F80: EDOP -> G = 16'h007F.
REQ-040 Sense load SA = 16'h0003, SAP = 0, TPARG_n = 0 -> one cycle later PERR = 1 for one cycle, then PALARM = 1 held until reset. A repeat with SAP = 1 -> no PERR.
REQ-041 Same-cycle RSA with SA = 16'h00F0 and WGG with W = 16'h000F, plus CGG = 1 -> G = 16'h00FF.
REQ-042 MONPAR = 1 during a write, followed by a sense load of that same G/GP with TPARG_n = 0 -> PERR pulses.
REQ-043 SIM_RST asserted in the CHECK cycle of a bad-parity load -> PERR stays 0, PALARM = 0, G = 16'h0000.
